// File: rtl/pattern_player.sv
// Siteswap juggling pattern player: walks a loaded throw pattern one beat per tick and
// tracks ball landings. Optional ball_count_out port enabled by PATTERN_PLAYER_BALL_COUNT_EN.
module pattern_player #(
   parameter int MAX_BALLS = 7
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic [6:0][2:0] pattern_in,
   input  logic [2:0]      pattern_length,
   input  logic            load_in,
   input  logic            beat_tick_in,
   output logic            throw_valid_out,
   output logic [2:0]      throw_height_out,
   output logic [2:0]      throw_ball_out,
   output logic            playing_out,
   output logic            error_out
`ifdef PATTERN_PLAYER_BALL_COUNT_EN
   ,
   output logic [2:0]      ball_count_out
`endif
);

   typedef enum logic [1:0] {IDLE, PLAY, ERROR} state_t;

   state_t          state_q, state_d;
   logic [6:0][2:0] pattern_q, pattern_d;
   logic [2:0]      len_q, len_d;
   logic [2:0]      pos_q, pos_d;
   logic [2:0]      next_ball_q, next_ball_d;
   logic [7:0]      occ_q, occ_d;
   logic [7:0][2:0] slot_ball_q, slot_ball_d;
   logic            vld_p0, vld_p1;
   logic [2:0]      height_p0, height_p1;
   logic [2:0]      ball_p0, ball_p1;
   logic [2:0]      h;
   logic [2:0]      thrown;
   logic            fault;

   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      len_d       = len_q;
      pos_d       = pos_q;
      next_ball_d = next_ball_q;
      occ_d       = occ_q;
      slot_ball_d = slot_ball_q;
      vld_p0      = 1'b0;
      height_p0   = height_p1;
      ball_p0     = ball_p1;
      h           = pattern_q[pos_q];
      thrown      = slot_ball_q[0];
      fault       = 1'b0;

      if (load_in && pattern_length != 3'd0) begin
         state_d     = PLAY;
         pattern_d   = pattern_in;
         len_d       = pattern_length;
         pos_d       = 3'd0;
         next_ball_d = 3'd0;
         occ_d       = '0;
         slot_ball_d = '0;
      end else if (state_q == PLAY && beat_tick_in) begin
         if (h == 3'd0) begin
            fault = occ_q[0];
         end else begin
            // a landing ball is rethrown; otherwise a fresh ball enters the pattern
            fault = occ_q[h];
            if (!occ_q[0]) begin
               thrown = next_ball_q;
               if (next_ball_q == 3'(MAX_BALLS))
                  fault = 1'b1;
            end
         end

         if (fault) begin
            state_d = ERROR;
         end else begin
            occ_d       = {1'b0, occ_q[7:1]};
            slot_ball_d = {3'b000, slot_ball_q[7:1]};
            pos_d       = (pos_q == len_q - 3'd1) ? 3'd0 : pos_q + 3'd1;
            if (h != 3'd0) begin
               occ_d[h - 3'd1]       = 1'b1;
               slot_ball_d[h - 3'd1] = thrown;
               vld_p0                = 1'b1;
               height_p0             = h;
               ball_p0               = thrown;
               if (!occ_q[0])
                  next_ball_d = next_ball_q + 3'd1;
            end
         end
      end
   end

   // p0 -> p1: schedule update and registered throw event
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         pattern_q   <= '0;
         len_q       <= 3'd0;
         pos_q       <= 3'd0;
         next_ball_q <= 3'd0;
         occ_q       <= '0;
         slot_ball_q <= '0;
         vld_p1      <= 1'b0;
         height_p1   <= 3'd0;
         ball_p1     <= 3'd0;
      end else begin
         state_q     <= state_d;
         pattern_q   <= pattern_d;
         len_q       <= len_d;
         pos_q       <= pos_d;
         next_ball_q <= next_ball_d;
         occ_q       <= occ_d;
         slot_ball_q <= slot_ball_d;
         vld_p1      <= vld_p0;
         height_p1   <= height_p0;
         ball_p1     <= ball_p0;
      end
   end

   assign throw_valid_out  = vld_p1;
   assign throw_height_out = height_p1;
   assign throw_ball_out   = ball_p1;
   assign playing_out      = (state_q == PLAY);
   assign error_out        = (state_q == ERROR);
`ifdef PATTERN_PLAYER_BALL_COUNT_EN
   assign ball_count_out   = next_ball_q;
`endif

endmodule

// File: doc/pattern_player.md
PATTERN_PLAYER -- requirements
Module: pattern_player

Interface
REQ-001 The block SHALL have parameter MAX_BALLS, default 7, the maximum number of distinct ball IDs the block may introduce (legal range 1..7).
REQ-002 The block SHALL have port clk_in  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port pattern_in  input  7x3 packed ([6:0][2:0])  siteswap throw heights; entry 0 is the first beat.
REQ-005 The block SHALL have port pattern_length  input  3  number of used entries in pattern_in (1..7).
REQ-006 The block SHALL have port load_in  input  1  single-cycle strobe that latches pattern_in and pattern_length and starts playback.
REQ-007 The block SHALL have port beat_tick_in  input  1  single-cycle strobe that advances playback by one beat.
REQ-008 The block SHALL have port throw_valid_out  output  1  one-cycle pulse marking a throw event.
REQ-009 The block SHALL have port throw_height_out  output  3  height of the current beat's throw.
REQ-010 The block SHALL have port throw_ball_out  output  3  ID of the ball thrown.
REQ-011 The block SHALL have port playing_out  output  1  high while in state PLAY.
REQ-012 The block SHALL have port error_out  output  1  sticky; high while in state ERROR.

Function
REQ-013 The block SHALL implement states IDLE, PLAY and ERROR; transitions: any state --load_in, length!=0--> PLAY; PLAY --collision/drop/ball overflow--> ERROR; no other transitions.
REQ-014 On load_in with pattern_length==0, the block SHALL ignore the load and leave state and all registers unchanged.
REQ-015 On an accepted load, the block SHALL latch the pattern, set beat position to 0, clear all 8 landing slots, and clear the next-ball counter.
REQ-016 If load_in and beat_tick_in are high in the same cycle, load SHALL win and the tick SHALL be dropped.
REQ-017 The block SHALL keep a landing schedule of 8 slots, each holding (occupied, ball ID); slot k means the ball lands k beats from now.
REQ-018 On beat_tick_in in PLAY, with h = pattern[pos], if h==0 and slot0 is occupied, the block SHALL flag a drop error.
REQ-019 If h==0 and slot0 is empty, the block SHALL shift the slots down by one and raise no throw.
REQ-020 If h>0, the thrown ball SHALL be the slot0 ball; if slot0 is empty, it SHALL be a new ball with ID = next-ball counter, after which the counter increments.
REQ-021 If h>0, slot0 is empty and the counter already equals MAX_BALLS, the block SHALL flag an overflow error.
REQ-022 If h>0 and pre-shift slot[h] is occupied, the block SHALL flag a collision error.
REQ-023 If h>0 and no error is flagged, the block SHALL shift the slots down by one and place the ball in post-shift slot h-1.
REQ-024 throw_valid_out, throw_height_out and throw_ball_out SHALL be registered and asserted exactly one clk_in cycle after the accepted tick, for one cycle; throw_height_out and throw_ball_out hold their values otherwise.
REQ-025 On an error-flagging tick, the block SHALL emit no throw, enter ERROR and hold all slots frozen.
REQ-026 Beat position SHALL increment per tick and wrap from pattern_length-1 to 0.
REQ-027 In IDLE and ERROR, the block SHALL ignore beat_tick_in.

Reset
REQ-028 While rst_n_in is low, the block SHALL immediately (asynchronously) enter IDLE, clear all slots, position and counter, and drive every output 0.
REQ-029 Reset asserted mid-playback SHALL abort playback with no further throw pulse.

Configuration
REQ-030 With PATTERN_PLAYER_BALL_COUNT_EN defined, the block SHALL add output port ball_count_out  output  3  current next-ball counter value, reset 0, cleared on load.
REQ-031 Without PATTERN_PLAYER_BALL_COUNT_EN, the port SHALL be absent and behaviour otherwise identical.

Verification
REQ-032 Pattern {3}, length 1, 7 ticks -> heights 3,3,3,3,3,3,3; balls 0,1,2,0,1,2,0; error_out stays 0.
REQ-033 Pattern {4,4,1}, length 3, 7 ticks -> heights 4,4,1,4,4,1,4; balls 0,1,2,2,0,1,1; no error.
REQ-034 Pattern {3,2}, length 2 -> tick 0 gives height 3 ball 0; tick 1 gives collision, no throw pulse, error_out=1, further ticks ignored.
REQ-035 Pattern {3,0}, length 2 -> throws at ticks 0 and 2; tick 3 drops ball 0, error_out=1.
REQ-036 load_in and beat_tick_in in the same cycle -> no throw pulse; next tick throws pattern[0]; a load while in ERROR clears error_out and restarts playback.
REQ-037 rst_n_in pulsed low mid-PLAY, asynchronous to clk_in -> all outputs 0 immediately; later ticks have no effect until the next load.
